fpga_core_2x2_fabric: RTL and testbench
=======================================

Name: fpga_core_2x2_fabric

Overview:
- Minimal island-style FPGA fabric: 2x2 array of configurable logic blocks (CLBs), each with one 4-input LUT and an optional output flip-flop.
- Programmable routing connects 4 primary inputs and 4 CLB outputs to CLB pins and 4 primary outputs.
- Configuration is loaded through two independent serial scan chains: CLB chain (LUT/FF config) and connection chain (routing selects).
- Sits at the top of the programmable core, below the chip pad ring.

Parameters:
- N_IO, 4, number of fpga_in and fpga_out bits; fixed at 4 because the select encoding depends on it.
- LUT_K, 4, LUT inputs per CLB; fixed at 4.
- CLB_LEN, 68 (derived), CLB chain length: 4 CLBs x 17 bits.
- CONN_LEN, 80 (derived), connection chain length: 16 pin selects + 4 output selects, 4 bits each.

Ports:
- clk  in  1  single clock; scan chains and CLB flip-flops.
- reset  in  1  asynchronous, active-low.
- fpga_in  in  4  primary user inputs.
- fpga_out  out  4  primary user outputs.
- clb_scan_in  in  1  CLB chain serial data.
- clb_scan_en  in  1  CLB chain shift enable.
- clb_scan_out  out  1  CLB chain serial out.
- conn_scan_in  in  1  connection chain serial data.
- conn_scan_en  in  1  connection chain shift enable.
- conn_scan_out  out  1  connection chain serial out.

Behaviour:
- Chain shifting:
  - For each chain cfg[LEN-1:0]: on a clk rising edge with its scan_en=1, cfg <= {scan_in, cfg[LEN-1:1]}.
  - scan_out = cfg[0] (combinational from the register).
  - The first bit shifted lands in bit 0 after LEN shifts.
  - With scan_en=0 the chain holds.
  - Both chains may shift in the same cycle, independently.
- Config registers are not reset. reset does not disturb loaded configuration. Contents are undefined until loaded.
- CLB chain layout, CLB k = 0..3 occupies bits [17k+16:17k]:
  - [15:0] LUT truth table, output = tt[{in3,in2,in1,in0}].
  - [16] reg_sel: 1 = CLB output from FF, 0 = combinational LUT output.
- Connection chain layout:
  - Bits [4(4k+p)+3 : 4(4k+p)] select CLB k pin p, for k,p = 0..3 (bits 0..63).
  - Bits [64+4j+3 : 64+4j] select fpga_out[j] (bits 64..79).
- Select codes:
  - 0-3 = fpga_in[0..3]
  - 4-7 = CLB output 0..3
  - 8 = constant 0
  - 9 = constant 1
  - 10-15 = constant 0
- CLB FF:
  - reset low clears all 4 FFs to 0 immediately (asynchronous). Release is synchronous-safe.
  - Otherwise the FF captures the LUT output on the clk rising edge only when clb_scan_en=0 and conn_scan_en=0. It holds while either chain shifts.
- Timing:
  - fpga_out is purely combinational from the selected source.
  - Combinational path: fpga_in to fpga_out in 0 cycles.
  - Registered path: 1 cycle after the LUT input settles.
- Combinational loops (a reg_sel=0 CLB routed back to itself through LUT pins) are an illegal configuration. Behaviour is undefined and must not be checked.
- During shifting, fpga_out follows the partially loaded config. There is no gating.

Optional Feature:
- Macro FPGA_CORE_FF_INIT_EN.
- When defined:
  - Each CLB gains bit [17] init, making 18 bits per CLB: CLB k occupies [18k+17:18k], CLB_LEN = 72.
  - reset low loads each FF with its init bit instead of 0.
- When undefined: 17-bit layout as above, FFs reset to 0.

Test Plan:
1. AND gate:
   - Load CLB0 tt=16'h8888, reg_sel=0.
   - Route CLB0 pin0 = code 1, pin1 = code 2, pins 2-3 = code 8; fpga_out[0] = code 4.
   - Apply fpga_in[2:1] = 11 -> fpga_out[0]=1; inputs 00, 01, 10 -> fpga_out[0]=0.
2. Chain pass-through:
   - Shift 80 bits with conn_scan_en=1, first bit 1, rest 0.
   - conn_scan_out=1 after exactly 80 shifts. clb_scan_out stays independent.
3. Registered output:
   - CLB1 tt=16'hAAAA (buffer of pin0), reg_sel=1, pin0 = code 0, fpga_out[1] = code 5.
   - Toggle fpga_in[0]=1 -> fpga_out[1] rises 1 clk later.
   - reset low mid-cycle -> fpga_out[1]=0 at once. Configuration unchanged after release.
4. Constants and unused codes: fpga_out[3] = code 9 -> 1; code 12 -> 0.
5. Hold during scan: with the registered CLB from test 3, assert clb_scan_en and change fpga_in[0] -> FF holds its value until scan_en drops.
6. FPGA_CORE_FF_INIT_EN build: set init=1 on CLB2, pulse reset -> CLB2 FF = 1. The other CLBs' FFs = 0.

Source files
------------

// File: rtl/fpga_core_2x2_fabric_if.sv
// fpga_core_2x2_fabric_if: user I/O and both configuration scan chains of the 2x2 fabric
interface fpga_core_2x2_fabric_if;
    logic [3:0] fpga_in;
    logic [3:0] fpga_out;
    logic       clb_scan_in;
    logic       clb_scan_en;
    logic       clb_scan_out;
    logic       conn_scan_in;
    logic       conn_scan_en;
    logic       conn_scan_out;

    modport master (
        output fpga_in, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
        input  fpga_out, clb_scan_out, conn_scan_out
    );

    modport slave (
        input  fpga_in, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
        output fpga_out, clb_scan_out, conn_scan_out
    );
endinterface

// File: rtl/fpga_core_2x2_fabric.sv
// fpga_core_2x2_fabric: 2x2 LUT4 island fabric with scan-loaded CLB and routing config
// Defining FPGA_CORE_FF_INIT_EN adds a per-CLB init bit that the reset loads into the CLB flip-flop.
module fpga_core_2x2_fabric (
    input logic                   clk,
    input logic                   reset,
    fpga_core_2x2_fabric_if.slave bus
);
`ifdef FPGA_CORE_FF_INIT_EN
    localparam int CLB_W = 18;
`else
    localparam int CLB_W = 17;
`endif
    localparam int CLB_LEN  = 4 * CLB_W;
    localparam int CONN_LEN = 80;

    logic [CLB_LEN-1:0]  clb_cfg;
    logic [CONN_LEN-1:0] conn_cfg;
    logic [3:0]          ff;
    logic [3:0]          lut;
    logic [3:0]          ff_init;
    logic [3:0]          reg_sel;
    logic [3:0][15:0]    tt;
    logic [15:0]         out_src;

    assign bus.clb_scan_out  = clb_cfg[0];
    assign bus.conn_scan_out = conn_cfg[0];

    for (genvar k = 0; k < 4; k++) begin : g_clb
        assign tt[k]      = clb_cfg[CLB_W*k +: 16];
        assign reg_sel[k] = clb_cfg[CLB_W*k + 16];
`ifdef FPGA_CORE_FF_INIT_EN
        assign ff_init[k] = clb_cfg[CLB_W*k + 17];
`else
        assign ff_init[k] = 1'b0;
`endif
    end

    // CLB outputs are resolved through four unrolled evaluation levels instead of a
    // feedback net: any legal (acyclic) routing is at most four CLBs deep, so level 3
    // is exact, and the netlist stays free of structural combinational loops.
    for (genvar i = 0; i < 4; i++) begin : g_lvl
        logic [3:0]  prev;
        logic [3:0]  o;
        logic [15:0] src;
        if (i == 0) begin : g_seed
            assign prev = '0;
        end else begin : g_chain
            assign prev = g_lvl[i-1].o;
        end
        // codes: 0-3 fpga_in, 4-7 CLB outputs, 8 const 0, 9 const 1, 10-15 const 0
        assign src = {6'b0, 2'b10, prev, bus.fpga_in};
        for (genvar k = 0; k < 4; k++) begin : g_k
            logic [3:0] pin;
            for (genvar p = 0; p < 4; p++) begin : g_p
                assign pin[p] = src[conn_cfg[4*(4*k+p) +: 4]];
            end
            assign o[k] = reg_sel[k] ? ff[k] : tt[k][pin];
            if (i == 3) begin : g_lut
                assign lut[k] = tt[k][pin];
            end
        end
    end

    assign out_src = {6'b0, 2'b10, g_lvl[3].o, bus.fpga_in};

    for (genvar j = 0; j < 4; j++) begin : g_out
        assign bus.fpga_out[j] = out_src[conn_cfg[64 + 4*j +: 4]];
    end

    // Scan chains shift toward bit 0 independently; configuration is never reset.
    always_ff @(posedge clk) begin
        if (bus.clb_scan_en)
            clb_cfg <= {bus.clb_scan_in, clb_cfg[CLB_LEN-1:1]};
        if (bus.conn_scan_en)
            conn_cfg <= {bus.conn_scan_in, conn_cfg[CONN_LEN-1:1]};
    end

    // CLB flip-flops: async reset to their init value, frozen while either chain shifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ff <= ff_init;
        else if (!bus.clb_scan_en && !bus.conn_scan_en)
            ff <= lut;
    end
endmodule

// File: tb/tb_fpga_core_2x2_fabric.sv
// tb_fpga_core_2x2_fabric: scoreboard bench for the 2x2 fabric with directed vectors
module tb_fpga_core_2x2_fabric;
`ifdef FPGA_CORE_FF_INIT_EN
    localparam int   CLB_W = 18;
    localparam logic INIT2 = 1'b1;
`else
    localparam int   CLB_W = 17;
    localparam logic INIT2 = 1'b0;
`endif
    localparam int CLB_LEN = 4 * CLB_W;

    typedef struct {
        string      name;
        int         sig;
        logic [3:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    logic [3:0] mon_act;
    int compared = 0;
    int mismatched = 0;
    logic [79:0] clb_img;
    logic [79:0] conn_img;
    logic [79:0] conn_img2;

    fpga_core_2x2_fabric_if bus();

    fpga_core_2x2_fabric dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Monitor: on every falling edge, compare the DUT against all pending expectations.
    initial forever begin
        @(negedge clk);
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_act = (mon_e.sig == 0) ? bus.fpga_out :
                      (mon_e.sig == 1) ? {3'b0, bus.clb_scan_out} : {3'b0, bus.conn_scan_out};
            compared++;
            if (mon_act !== mon_e.exp) begin
                mismatched++;
                $display("FAIL %s: got %b, expected %b", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic expect_sig(input string name, input int sig, input logic [3:0] exp);
        exp_t e;
        e.name = name;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL sync: %0d expectations left unsampled, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(inout logic [79:0] img, input int idx, input logic [3:0] code);
        img[4*idx +: 4] = code;
    endtask

    task automatic set_clb(input int k, input logic [15:0] t, input logic rs, input logic init);
        clb_img[CLB_W*k +: 16] = t;
        clb_img[CLB_W*k + 16] = rs;
        if (CLB_W == 18)
            clb_img[CLB_W*k + 17] = init;
    endtask

    task automatic shift(input logic [79:0] cb, input int cn, input logic [79:0] nb, input int nn);
        for (int i = 0; i < ((cn > nn) ? cn : nn); i++) begin
            bus.clb_scan_en = (i < cn);
            bus.clb_scan_in = (i < cn) ? cb[i] : 1'b0;
            bus.conn_scan_en = (i < nn);
            bus.conn_scan_in = (i < nn) ? nb[i] : 1'b0;
            step();
        end
        bus.clb_scan_en = 1'b0;
        bus.conn_scan_en = 1'b0;
        bus.clb_scan_in = 1'b0;
        bus.conn_scan_in = 1'b0;
    endtask

    initial begin
        bus.fpga_in = 4'b0000;
        bus.clb_scan_in = 1'b0;
        bus.clb_scan_en = 1'b0;
        bus.conn_scan_in = 1'b0;
        bus.conn_scan_en = 1'b0;
        clb_img = '0;
        set_clb(0, 16'h8888, 1'b0, 1'b0);
        set_clb(1, 16'hAAAA, 1'b1, 1'b0);
        set_clb(2, 16'h0000, 1'b1, 1'b1);
        set_clb(3, 16'h0000, 1'b0, 1'b0);
        conn_img = {20{4'h8}};
        set_sel(conn_img, 0, 4'd1);
        set_sel(conn_img, 1, 4'd2);
        set_sel(conn_img, 4, 4'd0);
        set_sel(conn_img, 16, 4'd4);
        set_sel(conn_img, 17, 4'd5);
        set_sel(conn_img, 18, 4'd6);
        set_sel(conn_img, 19, 4'd9);
        conn_img2 = conn_img;
        set_sel(conn_img2, 18, 4'd3);
        set_sel(conn_img2, 19, 4'd12);

        repeat (2) step();
        reset = 1'b1;
        step();

        // CLB chain loaded, connection chain cleared to zeros
        shift(clb_img, CLB_LEN, '0, 80);
        expect_sig("clb_preload_out", 1, 4'd0);
        sync();

        // single 1 travels the connection chain; CLB chain must not move
        for (int n = 1; n <= 81; n++) begin
            bus.conn_scan_en = 1'b1;
            bus.conn_scan_in = (n == 1);
            step();
            bus.conn_scan_en = 1'b0;
            bus.conn_scan_in = 1'b0;
            if (n == 3 || n == 79 || n == 80 || n == 81) begin
                expect_sig($sformatf("conn_pass_%0d", n), 2, (n == 80) ? 4'd1 : 4'd0);
                expect_sig($sformatf("clb_indep_%0d", n), 1, 4'd0);
                sync();
            end
        end

        shift('0, 0, conn_img, 80);

        // reset held low: FFs at init, AND low, constant 1 on out3
        reset = 1'b0;
        expect_sig("reset_state", 0, {1'b1, INIT2, 2'b00});
        sync();
        reset = 1'b1;
        step();

        // AND gate on fpga_in[2:1], combinational
        bus.fpga_in = 4'b0000; expect_sig("and_00", 0, 4'b1000); sync();
        bus.fpga_in = 4'b0010; expect_sig("and_01", 0, 4'b1000); sync();
        bus.fpga_in = 4'b0100; expect_sig("and_10", 0, 4'b1000); sync();
        bus.fpga_in = 4'b0110; expect_sig("and_11", 0, 4'b1001); sync();
        bus.fpga_in = 4'b1110; expect_sig("and_11_in3", 0, 4'b1001); sync();
        bus.fpga_in = 4'b1000; expect_sig("and_00_in3", 0, 4'b1000); sync();

        // registered buffer of fpga_in[0] on out1, one cycle late
        bus.fpga_in = 4'b0001; expect_sig("reg_before_edge", 0, 4'b1000); sync();
        expect_sig("reg_after_edge", 0, 4'b1010); sync();
        bus.fpga_in = 4'b0111; expect_sig("reg_and_both", 0, 4'b1011); sync();

        // async reset mid-cycle clears out1 at once, config survives
        reset = 1'b0;
        expect_sig("reset_async", 0, {1'b1, INIT2, 2'b01});
        sync();
        reset = 1'b1;
        step();
        expect_sig("reset_cfg_kept", 0, 4'b1011);
        sync();

        // CLB chain rotated back to the same image: FF holds while shifting
        bus.fpga_in = 4'b0110;
        shift(clb_img, CLB_LEN, '0, 0);
        expect_sig("hold_during_scan", 0, 4'b1011);
        sync();
        expect_sig("capture_after_scan", 0, 4'b1001);
        sync();

        // out2 from fpga_in[3], out3 on unused code 12
        shift('0, 0, conn_img2, 80);
        expect_sig("code12_zero", 0, 4'b0001);
        sync();
        bus.fpga_in = 4'b1110;
        expect_sig("direct_in3", 0, 4'b0101);
        sync();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
